pet_stats_engine: RTL and testbench

PET_STATS_ENGINE -- requirements
Module: pet_stats_engine

---
 rtl/pet_stats_engine_pkg.sv | 26 ++
 rtl/pet_stats_engine_if.sv | 28 ++
 rtl/pet_stats_engine_tick_gen.sv | 27 ++
 rtl/pet_stats_engine.sv | 138 +++++++++++++
 tb/tb_pet_stats_engine.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pet_stats_engine_pkg.sv
// Shared definitions for the pet stats engine.
// Holds the ASCII command byte values, the pet life-cycle state encoding
// and the fixed channel indices for the default five-channel pet.
package pet_pkg;

    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] CMD_EAT   = 8'h65;  // 'e' -> hunger
    localparam logic [7:0] CMD_PLAY  = 8'h70;  // 'p' -> happiness
    localparam logic [7:0] CMD_DOC   = 8'h64;  // 'd' -> health
    localparam logic [7:0] CMD_BATH  = 8'h62;  // 'b' -> hygiene
    localparam logic [7:0] CMD_SLEEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_WAKE  = 8'h77;  // 'w'

    localparam int HUNGER  = 0;
    localparam int HAPPY   = 1;
    localparam int HEALTH  = 2;
    localparam int HYGIENE = 3;
    localparam int ENERGY  = 4;

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        ASLEEP = 2'd1,
        DEAD   = 2'd2
    } pet_state_t;

endpackage

// File: rtl/pet_stats_engine_if.sv
// Bus between the pet stats engine and its host.
//   inputs    : ASCII command byte, 0x00 when idle (host -> engine)
//   random    : random byte, only looked at on tick cycles (host -> engine)
//   stats     : packed stats, channel i at [i*STAT_W +: STAT_W] (engine -> host)
//   tick      : one-cycle pulse per tick (engine -> host)
//   second    : animation phase, toggles every tick (engine -> host)
//   pet_state : AWAKE / ASLEEP / DEAD (engine -> host)
interface pet_stats_engine_if #(
    parameter int NUM_STATS = 5,
    parameter int STAT_W    = 5
);
    logic [7:0]                  inputs;
    logic [7:0]                  random;
    logic [NUM_STATS*STAT_W-1:0] stats;
    logic                        tick;
    logic                        second;
    logic [1:0]                  pet_state;

    modport master (
        output inputs, random,
        input  stats, tick, second, pet_state
    );

    modport slave (
        input  inputs, random,
        output stats, tick, second, pet_state
    );
endinterface

// File: rtl/pet_stats_engine_tick_gen.sv
// Tick generator: free-running counter over 0..TICK_DIV-1.
//   clk, reset : clock and asynchronous active-high reset
//   tick       : registered pulse, high during the cycle in which the
//                counter holds TICK_DIV-1 (TICK_DIV must be at least 2)
module pet_tick_gen #(
    parameter int TICK_DIV = 27000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    // tick is registered, so it is raised one count early to line up
    // with the cycle where count == TICK_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == CNT_W'(TICK_DIV - 2));
            count <= (count == CNT_W'(TICK_DIV - 1)) ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/pet_stats_engine.sv
// Virtual pet stats engine.
// Stats rise randomly on each tick and are lowered by one-shot care
// commands; the pet can sleep (energy drains every other tick), wakes on
// command or when energy runs out, and dies once any stat saturates.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of pet_stats_engine_if (commands, random byte,
//                packed stats, tick, second, pet_state)
module pet_stats_engine
    import pet_pkg::*;
#(
    parameter int NUM_STATS = 5,
    parameter int STAT_W    = 5,
    parameter int STAT_MAX  = 15,
    parameter int TICK_DIV  = 27000000,
    parameter int CARE_STEP = 1
) (
    input logic              clk,
    input logic              reset,
    pet_stats_engine_if.slave bus
);
    localparam int              ENERGY_CH = NUM_STATS - 1;
    localparam logic [STAT_W-1:0] MAX_V   = STAT_W'(STAT_MAX);
    localparam logic [STAT_W-1:0] CARE_V  = STAT_W'(CARE_STEP);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic en);
        if (en && (v < MAX_V)) return v + 1'b1;
        return v;
    endfunction

    function automatic logic [STAT_W-1:0] sat_dec(input logic [STAT_W-1:0] v,
                                                  input logic [STAT_W-1:0] amt);
        return (v > amt) ? v - amt : '0;
    endfunction

    pet_state_t                  state;
    logic                        armed;
    logic                        second;
    logic                        tick;
    logic [NUM_STATS*STAT_W-1:0] stats_flat;
    logic [NUM_STATS-1:0]        at_max;
    logic [NUM_STATS-1:0]        care_sel;
    logic                        accept_care;
    logic                        accept_sleep;
    logic                        accept_wake;
    logic                        any_max;
    logic                        alive;
    logic                        asleep;
    logic [STAT_W-1:0]           energy;
    logic [2:0]                  rnd_sel;
    logic [4:0]                  unused_rnd_bits;

    pet_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rnd_sel         = bus.random[2:0];
    assign unused_rnd_bits = bus.random[7:3];
    assign alive           = (state != DEAD);
    assign asleep          = (state == ASLEEP);

    // Command decode. A command is only accepted while armed and valid for
    // the current state; anything else leaves the armed flag alone.
    always_comb begin
        care_sel = '0;
        case (bus.inputs)
            CMD_EAT:  care_sel[HUNGER]  = 1'b1;
            CMD_PLAY: care_sel[HAPPY]   = 1'b1;
            CMD_DOC:  care_sel[HEALTH]  = 1'b1;
            CMD_BATH: care_sel[HYGIENE] = 1'b1;
            default:  ;
        endcase
        accept_care  = armed && (state == AWAKE)  && (|care_sel);
        accept_sleep = armed && (state == AWAKE)  && (bus.inputs == CMD_SLEEP);
        accept_wake  = armed && (state == ASLEEP) && (bus.inputs == CMD_WAKE);
    end

    for (genvar i = 0; i < NUM_STATS; i++) begin : g_stat
        logic [STAT_W-1:0] value;
        logic              inc;
        logic [STAT_W-1:0] amt;

        // Care and sleep drain never coincide (different states), so a
        // single decrement amount covers both.
        always_comb begin
            inc = tick && (rnd_sel == 3'(i)) && !(asleep && (i == ENERGY_CH));
            amt = '0;
            if (accept_care && care_sel[i]) amt = CARE_V;
            if ((i == ENERGY_CH) && tick && asleep && second) amt = STAT_W'(1);
        end

        // Increment first, then decrement, in one register write.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) value <= '0;
            else if (alive) value <= sat_dec(sat_inc(value, inc), amt);
        end

        assign stats_flat[i*STAT_W +: STAT_W] = value;
        assign at_max[i] = (value == MAX_V);
    end

    assign any_max = |at_max;
    assign energy  = stats_flat[ENERGY_CH*STAT_W +: STAT_W];

    // Death is checked on the registered stats, so it lands one cycle after
    // the saturating update and overrides any sleep/wake in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= AWAKE;
            armed  <= 1'b1;
            second <= 1'b0;
        end else begin
            if (tick) second <= ~second;

            if (bus.inputs == CMD_IDLE) armed <= 1'b1;
            else if (accept_care || accept_sleep || accept_wake) armed <= 1'b0;

            case (state)
                AWAKE: begin
                    if (any_max) state <= DEAD;
                    else if (accept_sleep) state <= ASLEEP;
                end
                ASLEEP: begin
                    if (any_max) state <= DEAD;
                    else if ((energy == '0) || accept_wake) state <= AWAKE;
                end
                default: state <= DEAD;
            endcase
        end
    end

    assign bus.stats     = stats_flat;
    assign bus.tick      = tick;
    assign bus.second    = second;
    assign bus.pet_state = state;
endmodule

// File: tb/tb_pet_stats_engine.sv
module tb_pet_stats_engine;
    localparam int N    = 5;
    localparam int W    = 5;
    localparam int MAXV = 15;
    localparam int TD   = 4;
    localparam int CARE = 1;
    localparam int E    = N - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pet_stats_engine_if #(.NUM_STATS(N), .STAT_W(W)) bus ();

    pet_stats_engine #(
        .NUM_STATS (N),
        .STAT_W    (W),
        .STAT_MAX  (MAXV),
        .TICK_DIV  (TD),
        .CARE_STEP (CARE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: stats as plain integers, state 0=awake 1=asleep 2=dead,
    // tick position derived from the number of edges since reset release.
    int m_s[N];
    int m_state;
    bit m_second;
    bit m_armed;
    int m_cyc;

    typedef struct {
        logic [7:0]     cmd;
        logic [7:0]     rnd;
        bit             on_tick;
        logic [N*W-1:0] exp_stats;
        logic [1:0]     exp_state;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int a, input int b, input int c,
                                          input int d, input int e);
        pk = {W'(e), W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [N*W-1:0] mpack();
        logic [N*W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*W +: W] = W'(m_s[i]);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_s[i] = 0;
        m_state  = 0;
        m_second = 1'b0;
        m_armed  = 1'b1;
        m_cyc    = 0;
    endtask

    task automatic model_edge(input logic [7:0] cmd, input logic [7:0] rnd);
        bit tk;
        bit any_max;
        bit e_zero;
        bit acc;
        int care;
        int r;
        int ns[N];
        tk = (m_cyc % TD) == (TD - 1);
        any_max = 1'b0;
        for (int i = 0; i < N; i++) if (m_s[i] == MAXV) any_max = 1'b1;
        e_zero = (m_s[E] == 0);
        case (cmd)
            8'h65:   care = 0;
            8'h70:   care = 1;
            8'h64:   care = 2;
            8'h62:   care = 3;
            default: care = -1;
        endcase
        acc = m_armed && ((m_state == 0 && (care >= 0 || cmd == 8'h73)) ||
                          (m_state == 1 && cmd == 8'h77));
        for (int i = 0; i < N; i++) ns[i] = m_s[i];
        if (m_state != 2) begin
            if (tk) begin
                r = int'(rnd % 8);
                if (r < N && !(m_state == 1 && r == E))
                    ns[r] = (ns[r] < MAXV) ? ns[r] + 1 : MAXV;
                if (m_state == 1 && m_second)
                    ns[E] = (ns[E] > 0) ? ns[E] - 1 : 0;
            end
            if (acc && care >= 0) ns[care] = (ns[care] > CARE) ? ns[care] - CARE : 0;
        end
        if (m_state != 2) begin
            if (any_max) m_state = 2;
            else if (m_state == 1 && e_zero) m_state = 0;
            else if (acc && cmd == 8'h73) m_state = 1;
            else if (acc && cmd == 8'h77) m_state = 0;
        end
        if (cmd == 8'h00) m_armed = 1'b1;
        else if (acc) m_armed = 1'b0;
        if (tk) m_second = ~m_second;
        m_cyc++;
        for (int i = 0; i < N; i++) m_s[i] = ns[i];
    endtask

    task automatic check_model(input string tag);
        check({tag, "_stats"}, 64'(bus.stats), 64'(mpack()));
        check({tag, "_state"}, 64'(bus.pet_state), 64'(m_state));
        check({tag, "_tick"}, 64'(bus.tick), 64'((m_cyc % TD) == (TD - 1)));
        check({tag, "_second"}, 64'(bus.second), 64'(m_second));
    endtask

    // Called in the low phase; returns at the following falling edge.
    task automatic step(input logic [7:0] cmd, input logic [7:0] rnd, input string tag);
        bus.inputs = cmd;
        bus.random = rnd;
        @(posedge clk);
        model_edge(cmd, rnd);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic tick_step(input logic [7:0] cmd, input logic [7:0] rnd, input string tag);
        while ((m_cyc % TD) != (TD - 1)) step(8'h00, 8'h07, tag);
        step(cmd, rnd, tag);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_stats", 64'(bus.stats), 64'd0);
        check("rst_state", 64'(bus.pet_state), 64'd0);
        check("rst_tick", 64'(bus.tick), 64'd0);
        check("rst_second", 64'(bus.second), 64'd0);
        model_reset();
        bus.inputs = 8'h00;
        bus.random = 8'h00;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add(input logic [7:0] c, input logic [7:0] r, input bit t,
                       input logic [N*W-1:0] s);
        vec_t v;
        v.cmd = c;
        v.rnd = r;
        v.on_tick = t;
        v.exp_stats = s;
        v.exp_state = 2'd0;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] rnd;
        int sel;

        bus.inputs = 8'h00;
        bus.random = 8'h00;
        model_reset();

        add(8'h00, 8'h00, 1, pk(1, 0, 0, 0, 0));
        add(8'h00, 8'h00, 1, pk(2, 0, 0, 0, 0));
        add(8'h00, 8'h01, 1, pk(2, 1, 0, 0, 0));
        add(8'h65, 8'h07, 0, pk(1, 1, 0, 0, 0));
        for (int k = 0; k < 9; k++) add(8'h65, 8'h07, 0, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h07, 0, pk(1, 1, 0, 0, 0));
        add(8'h65, 8'h07, 0, pk(0, 1, 0, 0, 0));
        add(8'h00, 8'h07, 0, pk(0, 1, 0, 0, 0));
        add(8'h65, 8'h07, 0, pk(0, 1, 0, 0, 0));
        add(8'h00, 8'h07, 0, pk(0, 1, 0, 0, 0));
        add(8'h00, 8'h00, 1, pk(1, 1, 0, 0, 0));
        add(8'h65, 8'h00, 1, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h07, 0, pk(1, 1, 0, 0, 0));
        add(8'h70, 8'h01, 1, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h02, 1, pk(1, 1, 1, 0, 0));
        add(8'h41, 8'h07, 0, pk(1, 1, 1, 0, 0));
        add(8'h64, 8'h07, 0, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h07, 0, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h03, 1, pk(1, 1, 0, 1, 0));
        add(8'h62, 8'h07, 0, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h07, 0, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h05, 1, pk(1, 1, 0, 0, 0));
        add(8'h00, 8'h04, 1, pk(1, 1, 0, 0, 1));
        add(8'h00, 8'hF8, 1, pk(2, 1, 0, 0, 1));

        #2;
        check("init_stats", 64'(bus.stats), 64'd0);
        check("init_state", 64'(bus.pet_state), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].on_tick) tick_step(vecs[k].cmd, vecs[k].rnd, "vec");
            else step(vecs[k].cmd, vecs[k].rnd, "vec");
            check($sformatf("vec%0d_stats", k), 64'(bus.stats), 64'(vecs[k].exp_stats));
            check($sformatf("vec%0d_state", k), 64'(bus.pet_state), 64'(vecs[k].exp_state));
        end

        // Sleep: energy drains on alternate ticks, care ignored, wake command
        do_reset();
        for (int k = 0; k < 4; k++) tick_step(8'h00, 8'h04, "slp_pre");
        step(8'h73, 8'h07, "slp");
        check("slp_enter", 64'(bus.pet_state), 64'd1);
        for (int k = 0; k < 4; k++) tick_step(8'h00, 8'h04, "slp_tick");
        check("slp_energy", 64'(bus.stats[E*W +: W]), 64'd2);
        step(8'h65, 8'h07, "slp_e");
        check("slp_e_ignored", 64'(bus.stats), 64'(pk(0, 0, 0, 0, 2)));
        check("slp_e_state", 64'(bus.pet_state), 64'd1);
        step(8'h77, 8'h07, "slp_w");
        check("slp_wake", 64'(bus.pet_state), 64'd0);

        // Auto-wake when energy runs out
        do_reset();
        tick_step(8'h00, 8'h04, "aw_pre");
        step(8'h73, 8'h07, "aw_s");
        tick_step(8'h00, 8'h07, "aw_tick");
        check("aw_energy0", 64'(bus.stats[E*W +: W]), 64'd0);
        check("aw_still_asleep", 64'(bus.pet_state), 64'd1);
        step(8'h00, 8'h07, "aw_next");
        check("aw_awake", 64'(bus.pet_state), 64'd0);

        // Death by saturation, then frozen stats with tick/second running
        do_reset();
        for (int k = 0; k < 15; k++) tick_step(8'h00, 8'h02, "die_tick");
        check("die_ch2", 64'(bus.stats), 64'(pk(0, 0, 15, 0, 0)));
        check("die_not_yet", 64'(bus.pet_state), 64'd0);
        check("die_second15", 64'(bus.second), 64'd1);
        step(8'h00, 8'h07, "die_next");
        check("die_dead", 64'(bus.pet_state), 64'd2);
        tick_step(8'h64, 8'h02, "dead_tick");
        check("dead_second16", 64'(bus.second), 64'd0);
        step(8'h00, 8'h07, "dead_idle");
        step(8'h73, 8'h07, "dead_s");
        step(8'h00, 8'h07, "dead_idle2");
        tick_step(8'h65, 8'h00, "dead_tick2");
        check("dead_second17", 64'(bus.second), 64'd1);
        check("dead_frozen", 64'(bus.stats), 64'(pk(0, 0, 15, 0, 0)));
        check("dead_absorb", 64'(bus.pet_state), 64'd2);

        // Reset while asleep mid-count; first tick on the 4th cycle
        do_reset();
        for (int k = 0; k < 2; k++) tick_step(8'h00, 8'h04, "mr_pre");
        step(8'h73, 8'h07, "mr_s");
        step(8'h00, 8'h07, "mr_mid");
        do_reset();
        step(8'h00, 8'h07, "mr_c1");
        check("mr_tick_c1", 64'(bus.tick), 64'd0);
        step(8'h00, 8'h07, "mr_c2");
        check("mr_tick_c2", 64'(bus.tick), 64'd0);
        step(8'h00, 8'h07, "mr_c3");
        check("mr_tick_c3", 64'(bus.tick), 64'd1);
        step(8'h00, 8'h07, "mr_c4");
        check("mr_tick_c4", 64'(bus.tick), 64'd0);
        check("mr_stats", 64'(bus.stats), 64'd0);
        check("mr_state", 64'(bus.pet_state), 64'd0);

        // Randomized run against the model
        for (int it = 0; it < 1500; it++) begin
            if ((it % 200) == 199) do_reset();
            sel = $urandom_range(0, 9);
            case (sel)
                3:       cmd = 8'h65;
                4:       cmd = 8'h70;
                5:       cmd = 8'h64;
                6:       cmd = 8'h62;
                7:       cmd = 8'h73;
                8:       cmd = 8'h77;
                9:       cmd = 8'($urandom_range(0, 255));
                default: cmd = 8'h00;
            endcase
            rnd = 8'($urandom_range(0, 255));
            step(cmd, rnd, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
